// File: rtl/alu_op_sequencer_if.sv
// Request / ALU / write-back bundle for alu_op_sequencer.
// slave modport: the sequencer. master modport: the requester plus ALU and register-file side.
interface alu_op_sequencer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_aluop;
   logic [5:0]        req_funct;
   logic [REG_AW-1:0] req_rd;
   logic              req_b_zero;
   logic              alu_en;
   logic [3:0]        alu_control;
   logic [DATA_W-1:0] alu_result;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              busy;
   logic              err_div0;
   logic              err_illegal;

   modport slave (
      input  req_valid, req_aluop, req_funct, req_rd, req_b_zero, alu_result,
      output req_ready, alu_en, alu_control, wb_en, wb_addr, wb_data, busy,
             err_div0, err_illegal
   );

   modport master (
      output req_valid, req_aluop, req_funct, req_rd, req_b_zero, alu_result,
      input  req_ready, alu_en, alu_control, wb_en, wb_addr, wb_data, busy,
             err_div0, err_illegal
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Execute-stage ALU sequencer: decodes ALUOp/funct, holds alu_control for the op latency,
// then issues a one-cycle write-back or an error pulse.
// Optional macro ALU_SEQ_PERF_EN adds saturating perf_ops / perf_busy counters.
module alu_op_sequencer #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef ALU_SEQ_PERF_EN
   output logic [31:0]        perf_ops,
   output logic [31:0]        perf_busy,
`endif
   alu_op_sequencer_if.slave  bus
);

   if (MUL_LAT < 1 || MUL_LAT > 255) begin : g_bad_mul_lat
      $fatal(1, "alu_op_sequencer: MUL_LAT out of range 1..255");
   end
   if (DIV_LAT < 1 || DIV_LAT > 255) begin : g_bad_div_lat
      $fatal(1, "alu_op_sequencer: DIV_LAT out of range 1..255");
   end

   localparam logic [7:0] MulCnt = 8'(MUL_LAT - 1);
   localparam logic [7:0] DivCnt = 8'(DIV_LAT - 1);

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        code_q, code_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              ill_q, ill_d;
   logic              div0_q, div0_d;
   logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic       dec_illegal;
   logic       dec_is_div;
   logic [3:0] dec_code;
   logic [7:0] dec_cnt;
   logic       can_accept;

   // Decode the incoming request into control code, latency count and error class
   always_comb begin
      dec_code    = 4'b0000;
      dec_cnt     = 8'd0;
      dec_illegal = 1'b0;
      dec_is_div  = 1'b0;
      unique case (bus.req_aluop)
         2'b00: dec_code = 4'b0000;
         2'b10: begin
            unique case (bus.req_funct)
               6'b100000: dec_code = 4'b0010;
               6'b100100: dec_code = 4'b0110;
               6'b100001: begin
                  dec_code = 4'b1000;
                  dec_cnt  = MulCnt;
               end
               6'b100010: begin
                  dec_code   = 4'b1001;
                  dec_cnt    = DivCnt;
                  dec_is_div = 1'b1;
               end
               6'b100011: dec_code = 4'b0001;
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // State register and datapath flops, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         code_q    <= 4'b0000;
         rd_q      <= '0;
         ill_q     <= 1'b0;
         div0_q    <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         rd_q      <= rd_d;
         ill_q     <= ill_d;
         div0_q    <= div0_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign can_accept = (state_q != StExec);

   // Next-state: accept in IDLE/WB, count down in EXEC, capture result on the last EXEC cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      rd_d      = rd_q;
      ill_d     = ill_q;
      div0_d    = div0_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      unique case (state_q)
         StIdle, StWb: begin
            if (bus.req_valid && can_accept) begin
               code_d = dec_code;
               rd_d   = bus.req_rd;
               ill_d  = dec_illegal;
               div0_d = dec_is_div && bus.req_b_zero;
               // Errored requests skip the ALU entirely and report in WB
               if (dec_illegal || (dec_is_div && bus.req_b_zero)) begin
                  cnt_d   = 8'd0;
                  state_d = StWb;
               end else begin
                  cnt_d   = dec_cnt;
                  state_d = StExec;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StExec: begin
            if (cnt_q == 8'd0) begin
               wb_data_d = bus.alu_result;
               wb_addr_d = rd_q;
               state_d   = StWb;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state; ready is also gated by reset
   always_comb begin
      bus.req_ready   = rst_n && can_accept;
      bus.alu_en      = (state_q == StExec);
      bus.busy        = (state_q == StExec);
      bus.alu_control = (state_q == StExec) ? code_q : 4'b0000;
      bus.wb_en       = (state_q == StWb) && !ill_q && !div0_q;
      bus.err_illegal = (state_q == StWb) && ill_q;
      bus.err_div0    = (state_q == StWb) && div0_q;
      bus.wb_addr     = wb_addr_q;
      bus.wb_data     = wb_data_q;
   end

`ifdef ALU_SEQ_PERF_EN
   logic [31:0] perf_ops_q, perf_ops_d;
   logic [31:0] perf_busy_q, perf_busy_d;

   // Saturating event counters for write-backs and busy cycles
   always_comb begin
      perf_ops_d  = perf_ops_q;
      perf_busy_d = perf_busy_q;
      if (bus.wb_en && (perf_ops_q != 32'hFFFF_FFFF)) perf_ops_d = perf_ops_q + 32'd1;
      if (bus.busy && (perf_busy_q != 32'hFFFF_FFFF)) perf_busy_d = perf_busy_q + 32'd1;
   end

   // Perf counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_ops_q  <= 32'd0;
         perf_busy_q <= 32'd0;
      end else begin
         perf_ops_q  <= perf_ops_d;
         perf_busy_q <= perf_busy_d;
      end
   end

   assign perf_ops  = perf_ops_q;
   assign perf_busy = perf_busy_q;
`endif

endmodule
